// File: rtl/buffer_reader_pkg.sv
// Shared types and helpers for the row-buffer read engine.
// ADDR_W must be wide enough to address every row of the attached buffer.
package buffer_reader_pkg;

  localparam int ADDR_W = 4;

  typedef enum logic [1:0] {
    BR_IDLE  = 2'd0,
    BR_READ  = 2'd1,
    BR_DRAIN = 2'd2
  } br_state_e;

  // Row address increment that wraps back to row 0 after the last row.
  function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] addr,
                                                 input logic [ADDR_W-1:0] last_row);
    if (addr == last_row) begin
      return {ADDR_W{1'b0}};
    end else begin
      return addr + ADDR_W'(1);
    end
  endfunction

endpackage

// File: rtl/buffer_reader.sv
// Walks a run of consecutive buffer rows and streams them out over valid/ready.
// A single output register plus the load enable sustains one beat per cycle.
module buffer_reader
  import buffer_reader_pkg::*;
#(
  parameter int WIDTH = 384,
  parameter int DEPTH = 16,
  parameter int LEN_W = 5
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [LEN_W-1:0]  i_len,
  input  logic              i_abort,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_addr_rd,
  input  logic [WIDTH-1:0]  i_data_rd,
  output logic              o_valid,
  output logic [WIDTH-1:0]  o_data,
  output logic              o_last,
  input  logic              i_ready
);

  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(DEPTH - 1);
  localparam logic [LEN_W-1:0]  ONE_ROW  = LEN_W'(1);

  br_state_e          state_r;
  br_state_e          state_s;
  logic [ADDR_W-1:0]  addr_r;
  logic [LEN_W-1:0]   rem_r;
  logic               ld_s;
  logic               xfer_s;
  logic               run_start_s;
  logic               empty_start_s;
  logic               last_xfer_s;
  logic               abort_s;

  assign o_addr_rd = addr_r;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= BR_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state and per-cycle strobes; abort outranks load and transfer.
  always_comb begin
    state_s       = state_r;
    ld_s          = 1'b0;
    xfer_s        = o_valid && i_ready;
    run_start_s   = 1'b0;
    empty_start_s = 1'b0;
    last_xfer_s   = 1'b0;
    abort_s       = 1'b0;
    case (state_r)
      BR_IDLE: begin
        if (i_start && (i_len != {LEN_W{1'b0}})) begin
          run_start_s = 1'b1;
          state_s     = BR_READ;
        end else if (i_start) begin
          empty_start_s = 1'b1;
        end else begin
          state_s = BR_IDLE;
        end
      end
      BR_READ: begin
        if (i_abort) begin
          abort_s = 1'b1;
          state_s = BR_IDLE;
        end else begin
          ld_s = !o_valid || i_ready;
          if (ld_s && (rem_r == ONE_ROW)) begin
            state_s = BR_DRAIN;
          end else begin
            state_s = BR_READ;
          end
        end
      end
      BR_DRAIN: begin
        if (i_abort) begin
          abort_s = 1'b1;
          state_s = BR_IDLE;
        end else if (xfer_s && o_last) begin
          last_xfer_s = 1'b1;
          state_s     = BR_IDLE;
        end else begin
          state_s = BR_DRAIN;
        end
      end
      default: begin
        state_s = BR_IDLE;
      end
    endcase
  end

  // Address/count bookkeeping and the output beat register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      addr_r  <= {ADDR_W{1'b0}};
      rem_r   <= {LEN_W{1'b0}};
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      o_valid <= 1'b0;
      o_last  <= 1'b0;
      o_data  <= {WIDTH{1'b0}};
    end else begin
      o_busy <= (state_s != BR_IDLE);
      o_done <= empty_start_s || last_xfer_s;
      if (abort_s) begin
        o_valid <= 1'b0;
        o_last  <= 1'b0;
        rem_r   <= {LEN_W{1'b0}};
      end else if (run_start_s) begin
        addr_r <= i_base_addr;
        rem_r  <= i_len;
      end else if (ld_s) begin
        o_data  <= i_data_rd;
        o_valid <= 1'b1;
        o_last  <= (rem_r == ONE_ROW);
        addr_r  <= wrap_inc(addr_r, LAST_ROW);
        rem_r   <= rem_r - ONE_ROW;
      end else if (xfer_s) begin
        o_valid <= 1'b0;
        o_last  <= 1'b0;
      end else begin
        o_valid <= o_valid;
      end
    end
  end

endmodule
